// File: rtl/keypad_scanner_pkg.sv
// ----------------------------------------------------------------------------
// keypad_scanner_pkg: keypad FSM encodings, defaults and calculator key codes.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package keypad_scanner_pkg;

  localparam logic [1:0] KP_SCAN     = 2'd0;
  localparam logic [1:0] KP_DEBOUNCE = 2'd1;
  localparam logic [1:0] KP_PRESENT  = 2'd2;
  localparam logic [1:0] KP_RELEASE  = 2'd3;

  localparam int KP_DEBOUNCE_DEFAULT = 4;

  // Key code = row*4 + col for the calculator legend printed on the keypad.
  localparam logic [3:0] KC_7   = 4'h0;
  localparam logic [3:0] KC_8   = 4'h1;
  localparam logic [3:0] KC_9   = 4'h2;
  localparam logic [3:0] KC_DIV = 4'h3;
  localparam logic [3:0] KC_4   = 4'h4;
  localparam logic [3:0] KC_5   = 4'h5;
  localparam logic [3:0] KC_6   = 4'h6;
  localparam logic [3:0] KC_MUL = 4'h7;
  localparam logic [3:0] KC_1   = 4'h8;
  localparam logic [3:0] KC_2   = 4'h9;
  localparam logic [3:0] KC_3   = 4'hA;
  localparam logic [3:0] KC_SUB = 4'hB;
  localparam logic [3:0] KC_CLR = 4'hC;
  localparam logic [3:0] KC_0   = 4'hD;
  localparam logic [3:0] KC_EQ  = 4'hE;
  localparam logic [3:0] KC_ADD = 4'hF;

  // Lowest-index active-low row wins when several rows are pulled down.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rs);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_sync2.sv
// ----------------------------------------------------------------------------
// sync2: parameterized-width two-flop synchronizer, resets to all ones.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= {WIDTH{1'b1}};
      r_sync <= {WIDTH{1'b1}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ----------------------------------------------------------------------------
// keypad_scanner: 4x4 matrix scan with debounce, one key code per press.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE = KP_DEBOUNCE_DEFAULT,
  parameter int DW       = 8
) (
  input  logic       CLK,
  input  logic       CLEAR,
  input  logic       TICK,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  input  logic       KEY_READY
);

  localparam logic [DW-1:0] c_CNT_LAST = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] c_CNT_MAX  = {DW{1'b1}};

  logic [3:0]    w_rs;
  logic          w_press;
  logic          w_cnt_last;
  logic [DW-1:0] w_cnt_inc;

  logic [1:0]    r_state;
  logic [1:0]    r_col;
  logic [1:0]    r_row;
  logic [3:0]    r_pat;
  logic [DW-1:0] r_cnt;
  logic [3:0]    r_code;

  sync2 #(.WIDTH(4)) u_row_sync (
    .clk (CLK),
    .rst (CLEAR),
    .i_d (ROW),
    .o_q (w_rs)
  );

  assign w_press    = (w_rs != 4'hF);
  assign w_cnt_last = (r_cnt == c_CNT_LAST);
  assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      r_state <= KP_SCAN;
      r_col   <= 2'd0;
      r_row   <= 2'd0;
      r_pat   <= 4'hF;
      r_cnt   <= '0;
      r_code  <= 4'h0;
    end else begin
      case (r_state)
        KP_SCAN: begin
          if (TICK) begin
            if (w_press) begin
              r_pat   <= w_rs;
              r_row   <= lowest_low_row(w_rs);
              r_cnt   <= '0;
              r_state <= KP_DEBOUNCE;
            end else begin
              r_col <= r_col + 2'd1;
            end
          end
        end
        KP_DEBOUNCE: begin
          if (TICK) begin
            if (w_rs == r_pat) begin
              if (w_cnt_last) begin
                r_code  <= {r_row, r_col};
                r_state <= KP_PRESENT;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_col   <= r_col + 2'd1;
              r_state <= KP_SCAN;
            end
          end
        end
        // Acceptance takes priority; a coincident TICK is deliberately dropped.
        KP_PRESENT: begin
          if (KEY_READY) begin
            r_cnt   <= '0;
            r_state <= KP_RELEASE;
          end
        end
        KP_RELEASE: begin
          if (TICK) begin
            if (w_press) begin
              r_cnt <= '0;
            end else if (w_cnt_last) begin
              r_col   <= r_col + 2'd1;
              r_state <= KP_SCAN;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        default: r_state <= KP_SCAN;
      endcase
    end
  end

  assign COL       = ~(4'b0001 << r_col);
  assign KEY_CODE  = r_code;
  assign KEY_VALID = (r_state == KP_PRESENT);

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ----------------------------------------------------------------------------
// tb_keypad_scanner: directed table-driven bench with a behavioural keypad.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_keypad_scanner;

  logic        CLK = 1'b0;
  logic        CLEAR;
  logic        TICK;
  logic [3:0]  ROW;
  logic [3:0]  COL;
  logic [3:0]  KEY_CODE;
  logic        KEY_VALID;
  logic        KEY_READY;
  logic [15:0] keys;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] keys;
    logic        tick;
    logic        ready;
    logic [3:0]  col;
    logic        valid;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] c_cols[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scanner #(.DEBOUNCE(4), .DW(8)) dut (
    .CLK       (CLK),
    .CLEAR     (CLEAR),
    .TICK      (TICK),
    .ROW       (ROW),
    .COL       (COL),
    .KEY_CODE  (KEY_CODE),
    .KEY_VALID (KEY_VALID),
    .KEY_READY (KEY_READY)
  );

  always #5 CLK = ~CLK;

  // Pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !COL[c]) ROW[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] k, input logic t, input logic r,
                     input int ci, input logic v, input logic [3:0] code);
    vec_t e;
    e.keys = k; e.tick = t; e.ready = r;
    e.col = c_cols[ci]; e.valid = v; e.code = code;
    vecs.push_back(e);
  endtask

  task automatic step(input logic [15:0] k, input logic t, input logic r);
    keys = k;
    repeat (3) @(negedge CLK);
    TICK = t;
    KEY_READY = r;
    @(negedge CLK);
    TICK = 1'b0;
    KEY_READY = 1'b0;
  endtask

  initial begin
    CLEAR = 1'b1; TICK = 1'b0; KEY_READY = 1'b0; keys = 16'h0;

    // Reset/idle rotation
    for (int i = 0; i < 8; i++) add(16'h0, 1, 0, (i + 1) % 4, 0, 4'h0);
    // Clean press of key 9 on column 1
    add(16'h0, 1, 0, 1, 0, 4'h0);
    for (int i = 0; i < 4; i++) add(16'h0200, 1, 0, 1, 0, 4'h0);
    for (int i = 0; i < 11; i++) add(16'h0200, 1, 0, 1, 1, 4'h9);
    add(16'h0200, 0, 1, 1, 0, 4'h9);
    add(16'h0200, 1, 0, 1, 0, 4'h9);
    for (int i = 0; i < 3; i++) add(16'h0, 1, 0, 1, 0, 4'h9);
    add(16'h0, 1, 0, 2, 0, 4'h9);
    // Bounce on row 0 of column 2
    add(16'h0004, 1, 0, 2, 0, 4'h9);
    add(16'h0004, 1, 0, 2, 0, 4'h9);
    add(16'h0, 1, 0, 3, 0, 4'h9);
    add(16'h0, 1, 0, 0, 0, 4'h9);
    // Key 5 held for 20 ticks after acceptance
    add(16'h0, 1, 0, 1, 0, 4'h9);
    for (int i = 0; i < 4; i++) add(16'h0020, 1, 0, 1, 0, 4'h9);
    add(16'h0020, 1, 0, 1, 1, 4'h5);
    add(16'h0020, 0, 1, 1, 0, 4'h5);
    for (int i = 0; i < 20; i++) add(16'h0020, 1, 0, 1, 0, 4'h5);
    for (int i = 0; i < 3; i++) add(16'h0, 1, 0, 1, 0, 4'h5);
    add(16'h0, 1, 0, 2, 0, 4'h5);
    // Rows 1 and 3 on column 0
    add(16'h0, 1, 0, 3, 0, 4'h5);
    add(16'h0, 1, 0, 0, 0, 4'h5);
    for (int i = 0; i < 4; i++) add(16'h1010, 1, 0, 0, 0, 4'h5);
    add(16'h1010, 1, 0, 0, 1, 4'h4);

    repeat (3) @(negedge CLK);
    chk("reset_col", COL, 4'b1110);
    chk("reset_valid", {3'b0, KEY_VALID}, 4'h0);
    chk("reset_code", KEY_CODE, 4'h0);
    CLEAR = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].keys, vecs[i].tick, vecs[i].ready);
      chk($sformatf("v%0d_col", i), COL, vecs[i].col);
      chk($sformatf("v%0d_valid", i), {3'b0, KEY_VALID}, {3'b0, vecs[i].valid});
      chk($sformatf("v%0d_code", i), KEY_CODE, vecs[i].code);
    end

    // Asynchronous clear while presenting
    #2 CLEAR = 1'b1;
    #1;
    chk("clr_valid", {3'b0, KEY_VALID}, 4'h0);
    chk("clr_col", COL, 4'b1110);
    chk("clr_code", KEY_CODE, 4'h0);
    keys = 16'h0;
    @(negedge CLK);
    CLEAR = 1'b0;

    // KEY_READY held high consumes one CLK after KEY_VALID rises
    for (int i = 0; i < 4; i++) begin
      step(16'h0010, 1, 0);
      chk($sformatf("rdy_wait%0d", i), {3'b0, KEY_VALID}, 4'h0);
    end
    KEY_READY = 1'b1;
    repeat (3) @(negedge CLK);
    TICK = 1'b1;
    @(posedge CLK);
    #1;
    chk("rdy_rise", {3'b0, KEY_VALID}, 4'h1);
    chk("rdy_code", KEY_CODE, 4'h4);
    @(negedge CLK);
    TICK = 1'b0;
    @(posedge CLK);
    #1;
    chk("rdy_consumed", {3'b0, KEY_VALID}, 4'h0);
    @(negedge CLK);
    KEY_READY = 1'b0;

    // Coincident TICK and KEY_READY in PRESENT: that TICK is not counted
    for (int i = 0; i < 4; i++) step(16'h0, 1, 0);
    chk("same_col_start", COL, 4'b1101);
    for (int i = 0; i < 5; i++) step(16'h0020, 1, 0);
    chk("same_valid", {3'b0, KEY_VALID}, 4'h1);
    chk("same_code", KEY_CODE, 4'h5);
    step(16'h0, 1, 1);
    chk("same_accept", {3'b0, KEY_VALID}, 4'h0);
    for (int i = 0; i < 3; i++) step(16'h0, 1, 0);
    chk("same_frozen", COL, 4'b1101);
    step(16'h0, 1, 0);
    chk("same_resume", COL, 4'b1011);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
